// File: rtl/rdy_set_go_score.sv
// Ready/set/go reaction game scorer: phase sequencing FSM, BCD score counter,
// best-score register and a BCD display driver with leading-zero suppression.
module rdy_set_go_score #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned PHASE_TICKS = 1,
  parameter bit          SAT_MODE    = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  start,
  input  logic [1:0]            correct,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     blank,
  output logic                  playing,
  output logic                  game_over,
  output logic [4*DIGITS-1:0]   high_score
);

  localparam int unsigned W = 4 * DIGITS;

  typedef enum logic [2:0] {
    StIdle,
    StReady,
    StSet,
    StPlay,
    StOver
  } state_e;

  state_e       state_q, state_d;
  logic [7:0]   phase_cnt_q, phase_cnt_d;
  logic [W-1:0] score_q, score_d;
  logic [W-1:0] high_q, high_d;

  logic [W-1:0] score_inc;
  logic         score_max;
  logic         carry;
  logic         last_tick;
  logic [W-1:0] shown;
  logic         seen_nz;

  assign last_tick = tick && (phase_cnt_q == 8'(PHASE_TICKS - 1));

  // BCD increment with ripple carry; all-9s either wraps to 0 or saturates.
  always_comb begin
    score_inc = score_q;
    carry     = 1'b1;
    score_max = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (score_q[4*i +: 4] != 4'd9) score_max = 1'b0;
      if (carry) begin
        if (score_q[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
    if (score_max && SAT_MODE) score_inc = score_q;
  end

  // Next-state logic: game sequencing, scoring and best-score capture.
  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    score_d     = score_q;
    high_d      = high_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StReady;
          phase_cnt_d = '0;
        end
      end
      StReady, StSet: begin
        // Releasing start beats a coincident tick.
        if (!start) begin
          state_d     = StIdle;
          phase_cnt_d = '0;
        end else if (tick) begin
          if (last_tick) begin
            phase_cnt_d = '0;
            if (state_q == StReady) begin
              state_d = StSet;
            end else begin
              state_d = StPlay;
              score_d = '0;
            end
          end else begin
            phase_cnt_d = phase_cnt_q + 8'd1;
          end
        end
      end
      StPlay: begin
        // Abort discards the game; high score is left alone.
        if (!start) begin
          state_d = StIdle;
        end else if (correct == 2'b01) begin
          score_d = score_inc;
        end else if (correct[1]) begin
          state_d = StOver;
          // Valid BCD orders the same as plain binary.
          if (score_q > high_q) high_d = score_q;
        end
      end
      StOver: begin
        if (!start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      phase_cnt_q <= '0;
      score_q     <= '0;
      high_q      <= '0;
    end else begin
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      score_q     <= score_d;
      high_q      <= high_d;
    end
  end

  // Display driver: phase banners or a number with leading-zero suppression.
  always_comb begin
    digits    = '0;
    blank     = '0;
    shown     = '0;
    seen_nz   = 1'b0;
    playing   = (state_q == StPlay);
    game_over = (state_q == StOver);
    case (state_q)
      StReady: begin
        digits[11:0] = 12'hA4C;
        blank        = '1;
        blank[2:0]   = 3'b000;
      end
      StSet: begin
        digits[7:0] = 8'hBE;
        blank       = '1;
        blank[1:0]  = 2'b00;
      end
      default: begin
        shown  = (state_q == StIdle) ? high_q : score_q;
        digits = shown;
        for (int i = int'(DIGITS) - 1; i > 0; i--) begin
          if (shown[4*i +: 4] != 4'd0) seen_nz = 1'b1;
          blank[i] = !seen_nz;
        end
        blank[0] = 1'b0;
      end
    endcase
  end

  assign high_score = high_q;

endmodule

// File: tb/tb_rdy_set_go_score.sv
// Bench for rdy_set_go_score: a wrapping and a saturating instance share stimulus;
// a decimal game model feeds an expectation queue drained by a negedge monitor.
module tb_rdy_set_go_score;

  localparam int unsigned PT   = 1;
  localparam int unsigned MAXV = 9999;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic        start;
  logic [1:0]  correct;

  logic [15:0] dig_w, dig_s, hs_w, hs_s;
  logic [3:0]  blk_w, blk_s;
  logic        play_w, play_s, over_w, over_s;

  rdy_set_go_score #(.DIGITS(4), .PHASE_TICKS(PT), .SAT_MODE(1'b0)) u_wrap (
    .clk(clk), .reset(rst), .tick(tick), .start(start), .correct(correct),
    .digits(dig_w), .blank(blk_w), .playing(play_w), .game_over(over_w),
    .high_score(hs_w)
  );

  rdy_set_go_score #(.DIGITS(4), .PHASE_TICKS(PT), .SAT_MODE(1'b1)) u_sat (
    .clk(clk), .reset(rst), .tick(tick), .start(start), .correct(correct),
    .digits(dig_s), .blank(blk_s), .playing(play_s), .game_over(over_s),
    .high_score(hs_s)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] dig0, dig1, hs0, hs1;
    logic [3:0]  blk0, blk1;
    logic        play, over;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Model: 0 idle, 1 ready, 2 set, 3 play, 4 over; scores as plain integers.
  int          m_st;
  int          m_ticks;
  int unsigned m_sc[2];
  int unsigned m_hs[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int unsigned v);
    logic [15:0] r;
    int unsigned x;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic void model_reset();
    m_st    = 0;
    m_ticks = 0;
    for (int k = 0; k < 2; k++) begin
      m_sc[k] = 0;
      m_hs[k] = 0;
    end
  endfunction

  function automatic void model_clock();
    if (rst) begin
      model_reset();
      return;
    end
    case (m_st)
      0: if (start) begin m_st = 1; m_ticks = 0; end
      1, 2: begin
        if (!start) begin
          m_st = 0; m_ticks = 0;
        end else if (tick) begin
          m_ticks++;
          if (m_ticks == int'(PT)) begin
            m_ticks = 0;
            if (m_st == 1) m_st = 2;
            else begin m_st = 3; m_sc[0] = 0; m_sc[1] = 0; end
          end
        end
      end
      3: begin
        if (!start) m_st = 0;
        else if (correct == 2'b01) begin
          for (int k = 0; k < 2; k++)
            m_sc[k] = (m_sc[k] == MAXV) ? ((k == 1) ? MAXV : 0) : m_sc[k] + 1;
        end else if (correct >= 2'b10) begin
          m_st = 4;
          for (int k = 0; k < 2; k++) if (m_sc[k] > m_hs[k]) m_hs[k] = m_sc[k];
        end
      end
      default: if (!start) m_st = 0;
    endcase
  endfunction

  function automatic exp_t model_out();
    exp_t        e;
    logic [15:0] d[2];
    logic [3:0]  b[2];
    int unsigned v;
    for (int k = 0; k < 2; k++) begin
      if (m_st == 1) begin
        d[k] = 16'h0A4C; b[k] = 4'b1000;
      end else if (m_st == 2) begin
        d[k] = 16'h00BE; b[k] = 4'b1100;
      end else begin
        v    = (m_st == 0) ? m_hs[k] : m_sc[k];
        d[k] = to_bcd(v);
        b[k] = {v < 1000, v < 100, v < 10, 1'b0};
      end
    end
    e.dig0 = d[0]; e.dig1 = d[1]; e.blk0 = b[0]; e.blk1 = b[1];
    e.hs0  = to_bcd(m_hs[0]); e.hs1 = to_bcd(m_hs[1]);
    e.play = (m_st == 3); e.over = (m_st == 4);
    return e;
  endfunction

  // One clock: model consumes the inputs sampled at this edge, then new inputs go out.
  task automatic step(input logic r, input logic s, input logic t, input logic [1:0] c);
    @(posedge clk);
    model_clock();
    #1;
    rst = r; start = s; tick = t; correct = c;
    if (r) model_reset();
    q.push_back(model_out());
  endtask

  task automatic start_game();
    step(1'b0, 1'b1, 1'b0, 2'b00);
    step(1'b0, 1'b1, 1'b1, 2'b00);
    step(1'b0, 1'b1, 1'b1, 2'b00);
    step(1'b0, 1'b1, 1'b0, 2'b00);
  endtask

  task automatic play_n(input int n);
    repeat (n) step(1'b0, 1'b1, 1'b0, 2'b01);
  endtask

  task automatic finish_wrong();
    step(1'b0, 1'b1, 1'b0, 2'b10);
    step(1'b0, 1'b1, 1'b0, 2'b00);
  endtask

  task automatic release_start();
    step(1'b0, 1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  // Monitor: every cycle the DUTs present a display, compared against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("mon_dig_wrap", 32'(dig_w), 32'(e.dig0));
      chk("mon_dig_sat",  32'(dig_s), 32'(e.dig1));
      chk("mon_blk_wrap", 32'(blk_w), 32'(e.blk0));
      chk("mon_blk_sat",  32'(blk_s), 32'(e.blk1));
      chk("mon_hs_wrap",  32'(hs_w),  32'(e.hs0));
      chk("mon_hs_sat",   32'(hs_s),  32'(e.hs1));
      chk("mon_play",     32'({play_w, play_s}), 32'({e.play, e.play}));
      chk("mon_over",     32'({over_w, over_s}), 32'({e.over, e.over}));
    end
  end

  initial begin
    rst = 1'b1; start = 1'b1; tick = 1'b0; correct = 2'b01;
    model_reset();
    // Reset held with start and correct active.
    step(1'b1, 1'b1, 1'b0, 2'b01);
    chk("reset_digits", 32'(dig_w), 32'h0);
    chk("reset_blank",  32'(blk_w), 32'b1110);
    chk("reset_play",   32'(play_w), 32'h0);
    step(1'b0, 1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b0, 1'b0, 2'b00);

    // Phase banners and entry into play.
    step(1'b0, 1'b1, 1'b0, 2'b00);
    step(1'b0, 1'b1, 1'b1, 2'b00);
    chk("ready_digits", 32'(dig_w), 32'h0A4C);
    chk("ready_blank",  32'(blk_w), 32'b1000);
    step(1'b0, 1'b1, 1'b1, 2'b00);
    chk("set_digits", 32'(dig_w), 32'h00BE);
    chk("set_blank",  32'(blk_w), 32'b1100);
    step(1'b0, 1'b1, 1'b0, 2'b00);
    chk("play_flag",   32'(play_w), 32'h1);
    chk("play_digits", 32'(dig_w), 32'h0);
    chk("play_blank",  32'(blk_w), 32'b1110);

    // First game ends at 12.
    play_n(12);
    finish_wrong();
    chk("over_digits", 32'(dig_w), 32'h0012);
    chk("over_blank",  32'(blk_w), 32'b1100);
    chk("over_hs",     32'(hs_w),  32'h0012);
    chk("over_flag",   32'(over_w), 32'h1);
    repeat (3) step(1'b0, 1'b1, 1'b0, 2'b01);
    chk("over_held", 32'(over_w), 32'h1);
    release_start();

    // Lower second score leaves the best at 12.
    start_game();
    play_n(5);
    finish_wrong();
    chk("game2_digits", 32'(dig_w), 32'h0005);
    release_start();
    chk("idle_hs_digits", 32'(dig_w), 32'h0012);
    chk("idle_hs",        32'(hs_s),  32'h0012);

    // Start dropped in SET together with a tick.
    step(1'b0, 1'b1, 1'b0, 2'b00);
    step(1'b0, 1'b1, 1'b1, 2'b00);
    step(1'b0, 1'b0, 1'b1, 2'b00);
    chk("set_state", 32'(dig_w), 32'h00BE);
    step(1'b0, 1'b0, 1'b0, 2'b00);
    chk("set_abort", 32'({play_w, dig_w}), 32'h0012);

    // Start dropped in PLAY together with a wrong answer.
    start_game();
    play_n(3);
    step(1'b0, 1'b0, 1'b0, 2'b10);
    step(1'b0, 1'b0, 1'b0, 2'b00);
    chk("play_abort_over", 32'(over_w), 32'h0);
    chk("play_abort_hs",   32'(hs_w),   32'h0012);

    // Reset mid-play at score 7, correct pulses while in reset.
    start_game();
    play_n(7);
    step(1'b0, 1'b1, 1'b0, 2'b00);
    chk("pre_reset_score", 32'(dig_w), 32'h0007);
    step(1'b1, 1'b1, 1'b0, 2'b01);
    step(1'b1, 1'b1, 1'b0, 2'b01);
    step(1'b0, 1'b0, 1'b0, 2'b00);
    chk("post_reset_hs",  32'(hs_w),  32'h0);
    chk("post_reset_dig", 32'(dig_w), 32'h0);
    chk("post_reset_blk", 32'(blk_w), 32'b1110);

    // Roll over the all-9s boundary.
    start_game();
    play_n(9999);
    step(1'b0, 1'b1, 1'b0, 2'b00);
    chk("all9_wrap", 32'(dig_w), 32'h9999);
    chk("all9_sat",  32'(dig_s), 32'h9999);
    play_n(1);
    finish_wrong();
    chk("wrap_to_zero", 32'(dig_w), 32'h0000);
    chk("sat_holds",    32'(dig_s), 32'h9999);
    chk("sat_hs",       32'(hs_s),  32'h9999);
    release_start();

    // Random play.
    for (int n = 0; n < 4000; n++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 19) != 0),
           ($urandom_range(0, 2) == 0),
           2'($urandom_range(0, 3) == 0 ? $urandom_range(2, 3) : $urandom_range(0, 1)));
    end
    step(1'b0, 1'b0, 1'b0, 2'b00);

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
